// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage indices name the bits of the stage-valid vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int ZERO_REG = 31;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

endpackage

// File: rtl/pipe_valid_tracker.sv
// Per-stage valid bits for IF/ID, ID/EX, EX/MEM and MEM/WB.
// freeze holds every bit; otherwise the vector shifts, with IF/ID and ID/EX overridable.
module pipe_valid_tracker
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       hold_if,
  input  logic       clear_if,
  input  logic       clear_id,
  input  logic       freeze,
  output logic [3:0] valid
);

  logic [3:0] valid_q;
  logic [3:0] valid_d;

  // Next valid vector: freeze, or shift with IF/ID fill/hold/clear and ID/EX bubble.
  always_comb begin
    valid_d = valid_q;
    if (freeze) begin
      valid_d = valid_q;
    end else begin
      if (clear_if) begin
        valid_d[IFID] = 1'b0;
      end else if (hold_if) begin
        valid_d[IFID] = valid_q[IFID];
      end else begin
        valid_d[IFID] = advance;
      end
      valid_d[IDEX]  = clear_id ? 1'b0 : valid_q[IFID];
      valid_d[EXMEM] = valid_q[IDEX];
      valid_d[MEMWB] = valid_q[EXMEM];
    end
  end

  // Valid register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 4'b0000;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: decides per cycle whether the
// front end advances, stalls on a load-use, squashes on a taken branch or freezes on memory.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = pipe_ctrl_pkg::ZERO_REG,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [3:0]       stage_valid,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] ZR        = ZERO_REG[REG_W-1:0];
  localparam logic [1:0]       FLUSH_LEN = 2'(BR_PENALTY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  state_e           eff_s;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic brq_s, luh_s;
  logic pc_we_s, ifid_we_s, ifid_flush_s, idex_bubble_s, exmem_hold_s;
  logic advance_s, hold_if_s, clear_if_s, clear_id_s, freeze_s;
  logic [3:0] valid_s;

  assign brq_s = br_taken & valid_s[IDEX];
  assign luh_s = ex_mem_read & valid_s[IDEX] & valid_s[IFID] & (ex_rd != ZR) &
                 ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));

  // Decision logic; a returning MEM_WAIT acts as its saved state in the same cycle.
  always_comb begin
    eff_s         = (state_q == MEM_WAIT) ? saved_q : state_q;
    state_d       = eff_s;
    saved_d       = saved_q;
    fcnt_d        = fcnt_q;
    pc_we_s       = 1'b0;
    ifid_we_s     = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    exmem_hold_s  = 1'b0;
    advance_s     = 1'b0;
    hold_if_s     = 1'b0;
    clear_if_s    = 1'b0;
    clear_id_s    = 1'b0;
    freeze_s      = 1'b0;
    if (mem_busy) begin
      state_d      = MEM_WAIT;
      saved_d      = eff_s;
      exmem_hold_s = 1'b1;
      freeze_s     = 1'b1;
    end else if (eff_s == FLUSH) begin
      pc_we_s      = 1'b1;
      ifid_we_s    = 1'b1;
      ifid_flush_s = 1'b1;
      clear_if_s   = 1'b1;
      if (fcnt_q <= 2'd1) begin
        state_d = RUN;
        fcnt_d  = 2'd0;
      end else begin
        fcnt_d = fcnt_q - 2'd1;
      end
    end else if (brq_s) begin
      // The branch outranks a simultaneous load-use: its consumer is squashed anyway.
      pc_we_s       = 1'b1;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      clear_if_s    = 1'b1;
      clear_id_s    = 1'b1;
      if (BR_PENALTY > 2) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_LEN;
      end else begin
        state_d = RUN;
      end
    end else if (luh_s) begin
      idex_bubble_s = 1'b1;
      hold_if_s     = 1'b1;
      clear_id_s    = 1'b1;
      state_d       = RUN;
    end else begin
      pc_we_s   = 1'b1;
      ifid_we_s = 1'b1;
      advance_s = 1'b1;
      state_d   = RUN;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    if (!pc_we_s && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      fcnt_q  <= 2'd0;
      stall_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
    end
  end

  pipe_valid_tracker u_valid (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance_s),
    .hold_if  (hold_if_s),
    .clear_if (clear_if_s),
    .clear_id (clear_id_s),
    .freeze   (freeze_s),
    .valid    (valid_s)
  );

  // Controls are forced low while reset is held, whatever the inputs say.
  assign pc_we       = pc_we_s & reset;
  assign ifid_we     = ifid_we_s & reset;
  assign ifid_flush  = ifid_flush_s & reset;
  assign idex_bubble = idex_bubble_s & reset;
  assign exmem_hold  = exmem_hold_s & reset;
  assign stage_valid = valid_s;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares against the selected instance.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rn = 5'd1;
  logic [4:0] id_rm = 5'd2;
  logic       id_uses_rm = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = 5'd3;
  logic       br_taken = 1'b0;
  logic       mem_busy = 1'b0;

  logic        pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, exmem_hold_a;
  logic [3:0]  sv_a;
  logic [15:0] sc_a;
  logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, exmem_hold_b;
  logic [3:0]  sv_b;
  logic [2:0]  sc_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .BR_PENALTY(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a),
    .idex_bubble(idex_bubble_a), .exmem_hold(exmem_hold_a),
    .stage_valid(sv_a), .stall_count(sc_a)
  );

  pipe_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .BR_PENALTY(4), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b),
    .idex_bubble(idex_bubble_b), .exmem_hold(exmem_hold_b),
    .stage_valid(sv_b), .stall_count(sc_b)
  );

  typedef struct {
    logic [4:0] ctl;
    logic [3:0] sv;
    int         sc;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  logic       sel = 1'b0;
  logic [4:0] act_ctl;
  logic [3:0] act_sv;
  int         act_sc;

  // ctl packs {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold}.
  always_comb begin
    if (sel) begin
      act_ctl = {pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, exmem_hold_b};
      act_sv  = sv_b;
      act_sc  = int'(sc_b);
    end else begin
      act_ctl = {pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, exmem_hold_a};
      act_sv  = sv_a;
      act_sc  = int'(sc_a);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        vectors++;
        if ((act_ctl !== mon_e.ctl) || (act_sv !== mon_e.sv) || (act_sc != mon_e.sc)) begin
          miscompares++;
          $display("FAIL %s: ctl/valid/stalls got %b/%b/%0d expected %b/%b/%0d",
                   mon_e.name, act_ctl, act_sv, act_sc, mon_e.ctl, mon_e.sv, mon_e.sc);
        end
      end
    end
  end

  task automatic vec(input logic r, input logic [4:0] rn, input logic [4:0] rm,
                     input logic urm, input logic mrd, input logic [4:0] rd,
                     input logic br, input logic busy, input logic [4:0] ctl,
                     input logic [3:0] sv, input int sc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; id_rn = rn; id_rm = rm; id_uses_rm = urm;
    ex_mem_read = mrd; ex_rd = rd; br_taken = br; mem_busy = busy;
    e.ctl = ctl; e.sv = sv; e.sc = sc; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] ctl, input logic [3:0] sv, input int sc, input string nm);
    vec(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, ctl, sv, sc, nm);
  endtask

  task automatic busyv(input logic [4:0] ctl, input logic [3:0] sv, input int sc, input string nm);
    vec(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, ctl, sv, sc, nm);
  endtask

  task automatic brv(input logic [4:0] ctl, input logic [3:0] sv, input int sc, input string nm);
    vec(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, ctl, sv, sc, nm);
  endtask

  int sat_exp[7] = '{2, 3, 4, 5, 6, 7, 7};

  initial begin
    // Instance A: BR_PENALTY=2, 16-bit counter.
    vec(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'b00000, 4'b0000, 0, "reset_a");
    idle(5'b11000, 4'b0000, 0, "fill0");
    idle(5'b11000, 4'b0001, 0, "fill1");
    idle(5'b11000, 4'b0011, 0, "fill2");
    idle(5'b11000, 4'b0111, 0, "fill3");
    idle(5'b11000, 4'b1111, 0, "full0");
    idle(5'b11000, 4'b1111, 0, "full1");
    vec(1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'b00010, 4'b1111, 0, "luh_rn");
    vec(1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'b11000, 4'b1101, 1, "luh_cleared");
    vec(1'b1, 5'd31, 5'd2, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 5'b11000, 4'b1011, 1, "xzr_no_stall");
    idle(5'b11000, 4'b0111, 1, "refill");
    vec(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'b00010, 4'b1111, 1, "luh_rm");
    idle(5'b11000, 4'b1101, 2, "after_rm");
    vec(1'b1, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 5'b10110, 4'b1011, 2, "br_over_luh");
    idle(5'b11000, 4'b0100, 2, "post_br");
    busyv(5'b00001, 4'b1001, 2, "memwait0");
    busyv(5'b00001, 4'b1001, 3, "memwait1");
    busyv(5'b00001, 4'b1001, 4, "memwait2");
    idle(5'b11000, 4'b1001, 5, "memwait_resume");
    idle(5'b11000, 4'b0011, 5, "memwait_after");
    vec(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'b00001, 4'b0111, 5, "br_during_busy");
    brv(5'b10110, 4'b0111, 6, "br_after_wait");
    idle(5'b11000, 4'b1100, 6, "post_br2");

    @(negedge clk);
    #1;
    sel = 1'b1;

    // Instance B: BR_PENALTY=4, 3-bit counter for saturation.
    vec(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'b00000, 4'b0000, 0, "reset_b");
    idle(5'b11000, 4'b0000, 0, "b_fill0");
    idle(5'b11000, 4'b0001, 0, "b_fill1");
    idle(5'b11000, 4'b0011, 0, "b_fill2");
    idle(5'b11000, 4'b0111, 0, "b_fill3");
    brv(5'b10110, 4'b1111, 0, "b_br");
    idle(5'b11100, 4'b1100, 0, "b_flush1");
    idle(5'b11100, 4'b1000, 0, "b_flush2");
    idle(5'b11000, 4'b0000, 0, "b_run");
    idle(5'b11000, 4'b0001, 0, "b_refill0");
    idle(5'b11000, 4'b0011, 0, "b_refill1");
    brv(5'b10110, 4'b0111, 0, "b_br2");
    idle(5'b11100, 4'b1100, 0, "b_flush_a");
    busyv(5'b00001, 4'b1000, 0, "b_flush_busy0");
    busyv(5'b00001, 4'b1000, 1, "b_flush_busy1");
    idle(5'b11100, 4'b1000, 2, "b_flush_resume");
    idle(5'b11000, 4'b0000, 2, "b_run2");
    for (int i = 0; i < 7; i++) begin
      busyv(5'b00001, 4'b0001, sat_exp[i], $sformatf("b_sat%0d", i));
    end
    idle(5'b11000, 4'b0001, 7, "b_sat_hold0");
    idle(5'b11000, 4'b0011, 7, "b_sat_hold1");
    brv(5'b10110, 4'b0111, 7, "b_br3");
    idle(5'b11100, 4'b1100, 7, "b_flush_c");
    vec(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 5'b00000, 4'b0000, 0, "b_reset_midflush");
    idle(5'b11000, 4'b0000, 0, "b_run_after_reset");
    idle(5'b11000, 4'b0001, 0, "b_run_after_reset2");

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 64-bit 5-stage pipeline.
- Sits beside the pipeline registers and the delayed control flops.
- Decides each cycle whether PC, IF/ID, ID/EX and EX/MEM advance, hold, bubble or flush.
- Tracks per-stage valid bits and counts stall cycles for performance debug.

Parameters:
REG_W, 5, register index width
ZERO_REG, 31, index of XZR; never creates a hazard
BR_PENALTY, 2, younger instructions squashed on a taken branch; legal range 2..4
CNT_W, 16, stall counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
id_rn  input  REG_W  first source register of the instruction in ID
id_rm  input  REG_W  second source register of the instruction in ID
id_uses_rm  input  1  ID instruction reads id_rm
ex_mem_read  input  1  EX instruction is a load
ex_rd  input  REG_W  destination register of the EX instruction
br_taken  input  1  taken branch resolved in EX
mem_busy  input  1  data memory not ready; freezes the pipeline
pc_we  output  1  PC write enable
ifid_we  output  1  IF/ID register write enable
ifid_flush  output  1  clear IF/ID to a bubble
idex_bubble  output  1  load NOP controls into ID/EX
exmem_hold  output  1  hold EX/MEM and MEM/WB
stage_valid  output  4  valid bits: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
stall_count  output  CNT_W  saturating stall-cycle counter

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, flush counter=0, stage_valid=0, stall_count=0.
  - Outputs during reset: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, exmem_hold=0.
- Control outputs are combinational from registered state and current inputs. stage_valid and stall_count are registered.
- Qualified signals:
  - brq = br_taken & stage_valid[1].
  - load-use hazard luh = ex_mem_read & stage_valid[1] & stage_valid[0] & ex_rd!=ZERO_REG & (ex_rd==id_rn | (id_uses_rm & ex_rd==id_rm)).
- Priority within a cycle: mem_busy > brq > luh > normal advance.
- RUN, normal advance:
  - pc_we=1, ifid_we=1, others 0.
  - Valid shift: v0<=1, v1<=v0, v2<=v1, v3<=v2.
- RUN with luh (one-cycle stall):
  - pc_we=0, ifid_we=0, idex_bubble=1.
  - Valid: v0 holds, v1<=0, v2<=v1, v3<=v2.
  - No state change. The bubble clears luh on the next cycle; a second load-use on a different load re-triggers independently.
- RUN with brq:
  - pc_we=1 (loads target), ifid_flush=1, idex_bubble=1.
  - Valid: v0<=0, v1<=0, v2<=v1, v3<=v2.
  - If BR_PENALTY>2: go to FLUSH with counter=BR_PENALTY-2. Otherwise stay in RUN.
  - brq and luh in the same cycle: branch wins; the load-use consumer is squashed.
- FLUSH:
  - pc_we=1, ifid_we=1, ifid_flush=1; v0<=0, rest shift.
  - Counter decrements each cycle; go to RUN when it reaches 1.
  - mem_busy in FLUSH: hold everything, counter frozen.
- Any state with mem_busy=1:
  - Go to MEM_WAIT (takes effect the same cycle).
  - All enables low: pc_we=0, ifid_we=0, exmem_hold=1, ifid_flush=0, idex_bubble=0. stage_valid holds.
  - Upstream holds br_taken stable; it is serviced after the wait.
- MEM_WAIT:
  - Same outputs as above while mem_busy=1.
  - On mem_busy=0, return to the saved state (RUN or FLUSH) and evaluate normally in that cycle.
- stall_count:
  - Increments every cycle that pc_we=0 while reset is deasserted (luh stall or mem freeze).
  - Saturates at 2^CNT_W-1; no wrap.
- Pipeline fill after reset: stage_valid goes 0001, 0011, 0111, 1111 over 4 advancing cycles.
- Reset mid-FLUSH or mid-MEM_WAIT: immediate return to RUN with all valids cleared.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (RUN, FLUSH, MEM_WAIT).
  - ZERO_REG constant.
  - Stage index constants IFID=0, IDEX=1, EXMEM=2, MEMWB=3.
- Sub-module pipe_valid_tracker:
  - 4-bit valid shift register.
  - Inputs: advance, hold_if, clear_if, clear_id, freeze.
  - Same clk/reset convention as the parent.

Test Plan:
- Release reset, no hazards, 6 cycles -> stage_valid 0001, 0011, 0111, 1111, then stays; pc_we=1 every cycle; stall_count=0.
- ex_mem_read=1, ex_rd=5, id_rn=5 with pipe full -> exactly one cycle of pc_we=0, ifid_we=0, idex_bubble=1; stall_count=1; ex_rd=31 with id_rn=31 -> no stall.
- br_taken=1 with luh true in the same cycle, BR_PENALTY=2 -> ifid_flush=1, idex_bubble=1, pc_we=1; v0=v1=0 next cycle; no stall; stall_count unchanged.
- BR_PENALTY=4, br_taken -> ifid_flush high 3 consecutive cycles, then RUN.
- BR_PENALTY=4, mem_busy high 2 cycles mid-FLUSH -> flush resumes with the remaining count.
- mem_busy=1 for 3 cycles -> pc_we=0, exmem_hold=1, stage_valid frozen; stall_count +3; resume on the 4th cycle.
- Set stall_count near 2^CNT_W-1, then hold mem_busy -> counter saturates.
- Assert reset mid-FLUSH -> outputs and stage_valid cleared immediately (asynchronous, without waiting for a clock edge); RUN after release.
